vram_plotter: RTL and testbench

Write-side engine for the 1bpp monochrome framebuffer that the VGA adapter scans out. It accepts pixel commands (set, clear, toggle) and whole-screen fill commands from the CPU/bus side over a valid/ready handshake. It converts each command into read-modify-write or burst-write cycles on the video RAM write port. The video RAM is dual-port: the adapter owns the read port, this block owns the second port.

---
 rtl/vram_pkg.sv | 22 ++
 rtl/vram_plotter_if.sv | 23 ++
 rtl/vram_pixaddr.sv | 19 +
 rtl/vram_plotter.sv | 127 ++++++++++++
 tb/tb_vram_plotter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the framebuffer write engine.
// Geometry is a 320x200 1bpp frame, 40 bytes per row, MSB is the leftmost pixel.
package vram_pkg;
  localparam logic [1:0] OP_PSET = 2'd0;
  localparam logic [1:0] OP_PCLR = 2'd1;
  localparam logic [1:0] OP_PXOR = 2'd2;
  localparam logic [1:0] OP_FILL = 2'd3;

  localparam int FB_W      = 320;
  localparam int FB_H      = 200;
  localparam int FB_STRIDE = 40;
  localparam int FB_BYTES  = 8000;
  localparam logic [12:0] FB_LAST = 13'(FB_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_WR,
    S_FILL
  } state_t;
endpackage

// File: rtl/vram_plotter_if.sv
// Command bus plus video RAM write port of the plotter.
// The master side is the host together with the RAM; the slave side is the plotter.
interface vram_plotter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic        cmd_err;
  logic [15:0] vram_addr;
  logic [7:0]  vram_rdata;
  logic [7:0]  vram_wdata;
  logic        vram_we;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, vram_rdata,
    input  cmd_ready, cmd_err, vram_addr, vram_wdata, vram_we
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, vram_rdata,
    output cmd_ready, cmd_err, vram_addr, vram_wdata, vram_we
  );
endinterface

// File: rtl/vram_pixaddr.sv
// Maps a pixel coordinate to its byte offset, bit mask and in-range flag.
// Purely combinational so the scan-out side can share it.
module vram_pixaddr
  import vram_pkg::*;
(
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  output logic [12:0] offset,
  output logic [7:0]  mask,
  output logic        in_range
);
  logic [12:0] y_ext;

  // y*40 as two shifts so no multiplier is needed
  assign y_ext    = {5'b0, y};
  assign offset   = (y_ext << 5) + (y_ext << 3) + {7'b0, x[8:3]};
  assign mask     = 8'h80 >> x[2:0];
  assign in_range = (x < 9'(FB_W)) && (y < 8'(FB_H));
endmodule

// File: rtl/vram_plotter.sv
// Turns pixel set/clear/toggle and whole-screen fill commands into
// read-modify-write or burst-write cycles on the video RAM second port.
module vram_plotter
  import vram_pkg::*;
#(
  parameter logic [15:0] FB_BASE = 16'h0000
) (
  input  logic           CLOCK,
  input  logic           RESETN,
  vram_plotter_if.slave  bus
);
  state_t      state, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  mask_q, mask_d;
  logic [12:0] cnt, cnt_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [12:0] offset;
  logic [7:0]  mask;
  logic        in_range;
  logic        accept;

  vram_pixaddr u_pixaddr (
    .x        (bus.cmd_x),
    .y        (bus.cmd_y),
    .offset   (offset),
    .mask     (mask),
    .in_range (in_range)
  );

  assign accept = bus.cmd_valid && ready_q;

  always_comb begin
    state_d = state;
    op_d    = op_q;
    mask_d  = mask_q;
    cnt_d   = cnt;
    ready_d = ready_q;
    err_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state)
      S_IDLE: if (accept) begin
        if (bus.cmd_op == OP_FILL) begin
          state_d = S_FILL;
          cnt_d   = '0;
          addr_d  = FB_BASE;
          wdata_d = bus.cmd_x[7:0];
          we_d    = 1'b1;
          ready_d = 1'b0;
        end else if (in_range) begin
          state_d = S_RD;
          op_d    = bus.cmd_op;
          mask_d  = mask;
          addr_d  = FB_BASE + {3'b0, offset};
          ready_d = 1'b0;
        end else begin
          err_d   = 1'b1;
        end
      end
      S_RD: state_d = S_WT;
      // read data arrives this cycle; modify it into the registered write data
      S_WT: begin
        state_d = S_WR;
        we_d    = 1'b1;
        case (op_q)
          OP_PSET: wdata_d = bus.vram_rdata | mask_q;
          OP_PCLR: wdata_d = bus.vram_rdata & ~mask_q;
          default: wdata_d = bus.vram_rdata ^ mask_q;
        endcase
      end
      S_WR: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      S_FILL: begin
        if (cnt == FB_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d  = cnt + 13'd1;
          addr_d = FB_BASE + {3'b0, 13'(cnt + 13'd1)};
          we_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state   <= S_IDLE;
      op_q    <= OP_PSET;
      mask_q  <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      cnt     <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.cmd_err    = err_q;
  assign bus.vram_we    = we_q;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_wdata = wdata_q;
endmodule

// File: tb/tb_vram_plotter.sv
// Directed bench: stimulus pushes expected writes/errors into queues,
// a negedge monitor pops and compares whenever the plotter writes or flags an error.
module tb_vram_plotter;
  import vram_pkg::*;

  logic CLOCK  = 1'b0;
  logic RESETN = 1'b1;
  always #5 CLOCK = ~CLOCK;

  vram_plotter_if b0();
  vram_plotter_if b1();

  vram_plotter #(.FB_BASE(16'h0000)) dut    (.CLOCK(CLOCK), .RESETN(RESETN), .bus(b0));
  vram_plotter #(.FB_BASE(16'hFFF0)) dut_hi (.CLOCK(CLOCK), .RESETN(RESETN), .bus(b1));

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;

  wr_t         q0[$];
  wr_t         q1[$];
  logic [31:0] qerr[$];
  wr_t         m0, m1;
  logic [31:0] merr;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc = 0;

  bit [7:0] mem0 [65536];
  bit [7:0] mem1 [65536];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // synchronous RAM models, read-before-write
  always @(posedge CLOCK) begin
    b0.vram_rdata <= mem0[b0.vram_addr];
    if (b0.vram_we) mem0[b0.vram_addr] <= b0.vram_wdata;
    else if (poke_en) mem0[poke_addr] <= poke_data;
    b1.vram_rdata <= mem1[b1.vram_addr];
    if (b1.vram_we) mem1[b1.vram_addr] <= b1.vram_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLOCK) if (RESETN) begin
    if (b0.vram_we) begin
      if (q0.size() == 0) check("wr_unexpected", {16'h0, b0.vram_addr}, 32'hFFFF_FFFF);
      else begin
        m0 = q0.pop_front();
        check("wr_addr", {16'h0, b0.vram_addr}, {16'h0, m0.addr});
        check("wr_data", {24'h0, b0.vram_wdata}, {24'h0, m0.data});
        check("wr_cycle", cyc, m0.cyc);
      end
    end
    if (b1.vram_we) begin
      if (q1.size() == 0) check("hi_wr_unexpected", {16'h0, b1.vram_addr}, 32'hFFFF_FFFF);
      else begin
        m1 = q1.pop_front();
        check("hi_wr_addr", {16'h0, b1.vram_addr}, {16'h0, m1.addr});
        check("hi_wr_data", {24'h0, b1.vram_wdata}, {24'h0, m1.data});
        check("hi_wr_cycle", cyc, m1.cyc);
      end
    end
    if (b0.cmd_err) begin
      if (qerr.size() == 0) check("err_unexpected", 1, 0);
      else begin
        merr = qerr.pop_front();
        check("err_cycle", cyc, merr);
      end
    end
    if (b1.cmd_err) check("hi_err_unexpected", 1, 0);
  end

  task automatic issue(input logic [1:0] op, input logic [8:0] x, input logic [7:0] y,
                       output logic [31:0] acc);
    int n = 0;
    @(negedge CLOCK);
    while (!b0.cmd_ready && n < 20000) begin
      @(negedge CLOCK);
      n++;
    end
    if (n >= 20000) check("ready_timeout", 0, 1);
    b0.cmd_valid = 1'b1;
    b0.cmd_op    = op;
    b0.cmd_x     = x;
    b0.cmd_y     = y;
    @(posedge CLOCK);
    #1;
    acc = cyc;
    b0.cmd_valid = 1'b0;
  endtask

  // pixel op: write in T+3, ready low T+1..T+3, back high at T+4
  task automatic pix(input logic [1:0] op, input logic [8:0] x, input logic [7:0] y,
                     input logic [15:0] ea, input logic [7:0] ed);
    logic [31:0] acc;
    int low = 0;
    issue(op, x, y, acc);
    q0.push_back(wr_t'{ea, ed, acc + 32'd2});
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK);
      if (!b0.cmd_ready) low++;
    end
    check("busy_ready_low", low, 3);
    @(negedge CLOCK);
    check("ready_back", {31'h0, b0.cmd_ready}, 1);
  endtask

  task automatic bad(input logic [8:0] x, input logic [7:0] y);
    logic [31:0] acc;
    issue(OP_PSET, x, y, acc);
    qerr.push_back(acc);
    @(negedge CLOCK);
    check("err_ready_high", {31'h0, b0.cmd_ready}, 1);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_ready"}, {31'h0, b0.cmd_ready}, 1);
    check({tag, "_err"},   {31'h0, b0.cmd_err}, 0);
    check({tag, "_we"},    {31'h0, b0.vram_we}, 0);
    check({tag, "_addr"},  {16'h0, b0.vram_addr}, 0);
    check({tag, "_wdata"}, {24'h0, b0.vram_wdata}, 0);
  endtask

  initial begin
    logic [31:0] acc;
    int n;
    b0.cmd_valid = 1'b0; b0.cmd_op = '0; b0.cmd_x = '0; b0.cmd_y = '0;
    b1.cmd_valid = 1'b0; b1.cmd_op = '0; b1.cmd_x = '0; b1.cmd_y = '0;
    #1 RESETN = 1'b0;
    #2 reset_outputs("rst");
    repeat (2) @(negedge CLOCK);
    RESETN = 1'b1;

    // base near top of the address space: 0xFFF0 + 7999 wraps to 0x1F2F
    @(negedge CLOCK);
    b1.cmd_valid = 1'b1; b1.cmd_op = OP_PSET; b1.cmd_x = 9'd319; b1.cmd_y = 8'd199;
    @(posedge CLOCK);
    #1;
    q1.push_back(wr_t'{16'h1F2F, 8'h01, cyc + 32'd2});
    b1.cmd_valid = 1'b0;
    repeat (5) @(negedge CLOCK);

    pix(OP_PSET, 9'd0, 8'd0, 16'd0, 8'h80);
    pix(OP_PSET, 9'd319, 8'd0, 16'd39, 8'h01);

    @(negedge CLOCK);
    poke_en = 1'b1; poke_addr = 16'd41; poke_data = 8'hFF;
    @(negedge CLOCK);
    poke_en = 1'b0;
    pix(OP_PCLR, 9'd13, 8'd1, 16'd41, 8'hFB);
    pix(OP_PXOR, 9'd13, 8'd1, 16'd41, 8'hFF);
    pix(OP_PXOR, 9'd13, 8'd1, 16'd41, 8'hFB);

    bad(9'd320, 8'd5);
    bad(9'd0, 8'd200);

    issue(OP_FILL, 9'h0AA, 8'd0, acc);
    for (int k = 0; k < FB_BYTES; k++) q0.push_back(wr_t'{16'(k), 8'hAA, acc + 32'(k)});
    @(negedge CLOCK);
    b0.cmd_valid = 1'b1; b0.cmd_op = OP_FILL; b0.cmd_x = 9'h055;
    repeat (5) @(negedge CLOCK);
    b0.cmd_valid = 1'b0;
    n = 0;
    while (!b0.cmd_ready && n < 9000) begin
      @(negedge CLOCK);
      n++;
    end
    check("fill_ready_cycle", cyc, acc + 32'd8000);
    check("fill_last_byte", {24'h0, mem0[7999]}, 32'hAA);
    check("fill_no_overrun", {24'h0, mem0[8000]}, 32'h00);

    // reset in the middle of the write of offset 100
    issue(OP_FILL, 9'h055, 8'd0, acc);
    for (int k = 0; k < 100; k++) q0.push_back(wr_t'{16'(k), 8'h55, acc + 32'(k)});
    n = 0;
    while (cyc != acc + 32'd100 && n < 200) begin
      @(posedge CLOCK);
      #1;
      n++;
    end
    #1 RESETN = 1'b0;
    #1 reset_outputs("fill_abort");
    repeat (2) @(negedge CLOCK);
    RESETN = 1'b1;
    check("fill_abort_pending", q0.size(), 0);
    check("fill_abort_99", {24'h0, mem0[99]}, 32'h55);
    check("fill_abort_100", {24'h0, mem0[100]}, 32'hAA);

    // reset during WT of a PCLR on offset 120: no write may land
    issue(OP_PCLR, 9'd0, 8'd3, acc);
    @(posedge CLOCK);
    #1;
    #1 RESETN = 1'b0;
    #1 check("wt_abort_we", {31'h0, b0.vram_we}, 0);
    check("wt_abort_ready", {31'h0, b0.cmd_ready}, 1);
    repeat (2) @(negedge CLOCK);
    RESETN = 1'b1;
    repeat (4) @(negedge CLOCK);
    check("wt_abort_ram", {24'h0, mem0[120]}, 32'hAA);

    pix(OP_PSET, 9'd8, 8'd2, 16'd81, 8'hD5);

    repeat (5) @(negedge CLOCK);
    check("q_pending", q0.size(), 0);
    check("hi_q_pending", q1.size(), 0);
    check("err_pending", qerr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
